// File: rtl/focus_pkg.sv
// Shared types and default geometry for the autofocus sharpness accumulator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package focus_pkg;

    localparam int H_RES    = 320;
    localparam int V_RES    = 240;
    localparam int ROI_X0   = 80;
    localparam int ROI_X1   = 239;
    localparam int ROI_Y0   = 60;
    localparam int ROI_Y1   = 179;
    localparam int NOISE_TH = 32;
    localparam int SCORE_W  = 28;
    localparam int XY_W     = 10;
    localparam int DATA_W   = 11;

    typedef enum logic {IDLE, ACCUM} focus_state_t;

    typedef logic [SCORE_W-1:0] score_t;

endpackage

// File: rtl/focus_score_if.sv
// Pixel stream in, frame focus result out, between sobel stage and motor controller.
// Latency: n/a (wiring only).
// Backpressure: result held on score_valid until score_ack; pixel side has none.
interface focus_score_if
    import focus_pkg::*;
#(
    parameter int SCORE_W = focus_pkg::SCORE_W
);
    logic                sobel_en;
    logic [XY_W-1:0]     x_pixel;
    logic [XY_W-1:0]     y_pixel;
    logic [DATA_W-1:0]   integrated_data;
    logic                clear_best;
    logic                score_ack;
    logic [SCORE_W-1:0]  focus_score;
    logic                score_valid;
    logic                improved;
    logic [SCORE_W-1:0]  best_score;
    logic [7:0]          frame_cnt;
    logic                overrun;

    // Accumulator side
    modport slave (
        input  sobel_en, x_pixel, y_pixel, integrated_data, clear_best, score_ack,
        output focus_score, score_valid, improved, best_score, frame_cnt, overrun
    );

    // Pixel source / result consumer side
    modport master (
        output sobel_en, x_pixel, y_pixel, integrated_data, clear_best, score_ack,
        input  focus_score, score_valid, improved, best_score, frame_cnt, overrun
    );

endinterface

// File: rtl/focus_score_accum_roi_gate.sv
// Per-pixel contribution: magnitude if strobed, inside the ROI and at/above noise floor.
// Latency: combinational.
// Backpressure: none.
module roi_gate
    import focus_pkg::*;
#(
    parameter int ROI_X0   = focus_pkg::ROI_X0,
    parameter int ROI_X1   = focus_pkg::ROI_X1,
    parameter int ROI_Y0   = focus_pkg::ROI_Y0,
    parameter int ROI_Y1   = focus_pkg::ROI_Y1,
    parameter int NOISE_TH = focus_pkg::NOISE_TH
) (
    input  logic [XY_W-1:0]   x_pixel,
    input  logic [XY_W-1:0]   y_pixel,
    input  logic [DATA_W-1:0] integrated_data,
    input  logic              sobel_en,
    output logic [DATA_W-1:0] c
);

    logic in_roi;
    logic above_th;

    // Inclusive ROI window and noise threshold; anything failing contributes zero.
    always_comb begin
        in_roi   = (x_pixel >= XY_W'(ROI_X0)) && (x_pixel <= XY_W'(ROI_X1)) &&
                   (y_pixel >= XY_W'(ROI_Y0)) && (y_pixel <= XY_W'(ROI_Y1));
        above_th = (integrated_data >= DATA_W'(NOISE_TH));
        c        = (sobel_en && in_roi && above_th) ? integrated_data : '0;
    end

endmodule

// File: rtl/focus_score_accum.sv
// Sums gated gradient magnitude over a frame, latches score and tracks best-since-clear.
// Latency: 1 cycle per pixel; result visible the cycle after the last pixel is sampled.
// Backpressure: result waits on score_ack; an unacked result overwritten sets sticky overrun.
module focus_score_accum
    import focus_pkg::*;
#(
    parameter int H_RES    = focus_pkg::H_RES,
    parameter int V_RES    = focus_pkg::V_RES,
    parameter int ROI_X0   = focus_pkg::ROI_X0,
    parameter int ROI_X1   = focus_pkg::ROI_X1,
    parameter int ROI_Y0   = focus_pkg::ROI_Y0,
    parameter int ROI_Y1   = focus_pkg::ROI_Y1,
    parameter int NOISE_TH = focus_pkg::NOISE_TH,
    parameter int SCORE_W  = focus_pkg::SCORE_W
) (
    input  logic           clk_25MHz,
    input  logic           reset,
    focus_score_if.slave   bus
);

    logic [DATA_W-1:0]  c;
    logic [SCORE_W-1:0] c_ext;
    logic [SCORE_W-1:0] acc;
    logic [SCORE_W-1:0] add_base;
    logic [SCORE_W:0]   sum_raw;
    logic [SCORE_W-1:0] sum_sat;
    logic [SCORE_W-1:0] best_eff;
    logic               first_px;
    logic               last_px;
    focus_state_t       state;

    logic [SCORE_W-1:0] focus_score_q;
    logic               score_valid_q;
    logic               improved_q;
    logic [SCORE_W-1:0] best_score_q;
    logic [7:0]         frame_cnt_q;
    logic               overrun_q;

    roi_gate #(
        .ROI_X0   (ROI_X0),
        .ROI_X1   (ROI_X1),
        .ROI_Y0   (ROI_Y0),
        .ROI_Y1   (ROI_Y1),
        .NOISE_TH (NOISE_TH)
    ) u_roi_gate (
        .x_pixel         (bus.x_pixel),
        .y_pixel         (bus.y_pixel),
        .integrated_data (bus.integrated_data),
        .sobel_en        (bus.sobel_en),
        .c               (c)
    );

    // Frame markers, saturating sum and the best score the comparison should use.
    always_comb begin
        first_px = (bus.x_pixel == XY_W'(0)) && (bus.y_pixel == XY_W'(0));
        last_px  = (bus.x_pixel == XY_W'(H_RES - 1)) && (bus.y_pixel == XY_W'(V_RES - 1));
        c_ext    = {{(SCORE_W - DATA_W){1'b0}}, c};
        // A (0,0) strobe restarts the frame, so the running sum is dropped.
        add_base = (state == ACCUM && !first_px) ? acc : '0;
        sum_raw  = {1'b0, add_base} + {1'b0, c_ext};
        sum_sat  = sum_raw[SCORE_W] ? {SCORE_W{1'b1}} : sum_raw[SCORE_W-1:0];
        // clear_best coinciding with a latch compares against zero.
        best_eff = bus.clear_best ? '0 : best_score_q;
    end

    // Frame FSM, accumulator, result latch and handshake registers.
    always_ff @(posedge clk_25MHz or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            acc           <= '0;
            focus_score_q <= '0;
            score_valid_q <= 1'b0;
            improved_q    <= 1'b0;
            best_score_q  <= '0;
            frame_cnt_q   <= '0;
            overrun_q     <= 1'b0;
        end else begin
            if (bus.clear_best) begin
                best_score_q <= '0;
            end
            if (score_valid_q && bus.score_ack) begin
                score_valid_q <= 1'b0;
            end
            if (bus.sobel_en) begin
                case (state)
                    IDLE: begin
                        if (first_px) begin
                            acc   <= sum_sat;
                            state <= ACCUM;
                        end
                    end
                    ACCUM: begin
                        if (last_px) begin
                            // Latch overrides a same-edge ack and a plain clear_best.
                            focus_score_q <= sum_sat;
                            improved_q    <= (sum_sat > best_eff);
                            best_score_q  <= (sum_sat > best_eff) ? sum_sat : best_eff;
                            frame_cnt_q   <= frame_cnt_q + 8'd1;
                            score_valid_q <= 1'b1;
                            if (score_valid_q && !bus.score_ack) begin
                                overrun_q <= 1'b1;
                            end
                            acc   <= '0;
                            state <= IDLE;
                        end else begin
                            acc <= sum_sat;
                        end
                    end
                    default: begin
                        acc   <= '0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.focus_score = focus_score_q;
    assign bus.score_valid = score_valid_q;
    assign bus.improved    = improved_q;
    assign bus.best_score  = best_score_q;
    assign bus.frame_cnt   = frame_cnt_q;
    assign bus.overrun     = overrun_q;

endmodule

// File: doc/focus_score_accum.md
# focus_score_accum

Frame-level sharpness accumulator placed directly downstream of `sobel_filter` in the motor-camera autofocus path. It sums the per-pixel gradient magnitude (`integrated_data`) over a fixed region of interest, ignoring values below a noise threshold. At end of frame it latches a focus score, compares it against the best score seen since the last clear, and presents the result to the motor controller over a valid/ack handshake.

## Interface
- `H_RES`, 320: active pixels per line.
- `V_RES`, 240: active lines per frame.
- `ROI_X0` / `ROI_X1`, 80 / 239: inclusive ROI column bounds.
- `ROI_Y0` / `ROI_Y1`, 60 / 179: inclusive ROI row bounds.
- `NOISE_TH`, 32: a magnitude below this value contributes 0.
- `SCORE_W`, 28: score width.
- `clk_25MHz`  in  1  pixel clock, the only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `sobel_en`  in  1  pixel strobe, same as fed to `sobel_filter`.
- `x_pixel`  in  10  current column.
- `y_pixel`  in  10  current row.
- `integrated_data`  in  11  unsigned gradient magnitude, 0..2040.
- `clear_best`  in  1  one-cycle pulse that zeroes `best_score`; issued at motor sweep start.
- `score_ack`  in  1  consumer acknowledge.
- `focus_score`  out  SCORE_W  last latched frame score.
- `score_valid`  out  1  result pending.
- `improved`  out  1  latched score was strictly greater than the previous `best_score`.
- `best_score`  out  SCORE_W  maximum score since reset or `clear_best`.
- `frame_cnt`  out  8  completed frames, wraps 255→0.
- `overrun`  out  1  sticky: a result was overwritten before it was acked.

## Operation
- **Contribution.** A pixel contributes `c = integrated_data` when all of these hold: `sobel_en` is high, the pixel is inside the ROI (inclusive bounds), and `integrated_data >= NOISE_TH`. Otherwise `c = 0`.
- **Accumulation.** `c` is zero-extended to SCORE_W and added into `acc`. The sum saturates at 2^SCORE_W−1 and never wraps.
- **FSM `IDLE`.**
  - `acc` holds 0.
  - On `sobel_en` with x=0, y=0: go to `ACCUM`, with `acc <= c`.
- **FSM `ACCUM`.**
  - Every strobed pixel adds `c`.
  - Last pixel (`sobel_en`, x=H_RES−1, y=V_RES−1): run the latch action, then go to `IDLE`.
  - Another (0,0) strobe before the last pixel means the frame was aborted: `acc <= c`, stay in `ACCUM`, no result is produced.
- **Latch action**, all at one clock edge:
  - Let `s = sat(acc + c)`.
  - `focus_score <= s`.
  - `improved <= (s > best_score)`.
  - `best_score <= max(best_score, s)`.
  - `frame_cnt` increments.
  - `score_valid <= 1`.
  - `overrun` sets if `score_valid` was 1 and `score_ack` was 0 at that edge.
- **Handshake.**
  - `score_valid` stays high until a cycle in which `score_ack` = 1; it clears at that edge.
  - If ack and latch occur on the same edge, the latch wins: `score_valid` stays 1 with the new data and no overrun.
  - `score_ack` while `score_valid` = 0 is ignored.
- **`clear_best`.**
  - Zeroes `best_score` at the next edge.
  - If it coincides with a latch, the comparison uses `best_score = 0`: `improved = (s > 0)` and `best_score <= s`.
- **`overrun`** clears only on reset.

## Timing
- All outputs reset to 0 and the FSM resets to `IDLE`.
- Reset mid-frame discards the partial sum. After deassertion, nothing accumulates until the next (0,0) strobe.
- Accumulation latency: 1 cycle per pixel. `acc` reflects pixel *n* after the edge at which it is sampled.
- Result latency: `focus_score`, `improved`, `best_score` and `score_valid` are updated at the same edge that samples the last pixel, so they are visible in the following cycle.
- Inputs are sampled only when `sobel_en` = 1. Gaps in `sobel_en` do not disturb state.
- Worst-case sum at defaults is 160·120·2040 = 39,168,000, below 2^26, so saturation is reachable only with a wider ROI or smaller SCORE_W.

## Structure
- Shared package `focus_pkg`:
  - `H_RES`, `V_RES`, `SCORE_W` as localparams.
  - `typedef enum logic {IDLE, ACCUM} focus_state_t`.
  - `typedef logic [SCORE_W-1:0] score_t`.
- One combinational sub-module, `roi_gate`: takes x, y, `integrated_data` and `sobel_en`; outputs `c`. It holds the ROI compare and the threshold.
- The top level holds the FSM, the saturating adder, the best-score tracker and the handshake registers.

## Test plan
- **Uniform frame.** `integrated_data`=100 on every pixel of one full frame, ack held low → `focus_score`=19200·100=1,920,000, `improved`=1, `best_score`=1,920,000, `frame_cnt`=1, `score_valid` high until ack.
- **Threshold and ROI.** Value 31 inside the ROI and 2040 outside it → `focus_score`=0, `improved`=0.
- **Two frames, no ack.** Two frames scoring 500 then 300, no ack between them → second result 300, `improved`=0, `best_score`=500, `overrun`=1. A third frame scoring 800 → `improved`=1, `best_score`=800.
- **Coincident events.** `score_ack` and last pixel on the same edge → `score_valid` stays 1, `overrun` stays 0. `clear_best` on the same edge as a latch of 200 with `best_score`=900 → `best_score`=200, `improved`=1.
- **Reset and abort.** Reset pulse at pixel (100,120) → all outputs 0. A partial frame followed by a fresh (0,0) → no `score_valid`. The next full frame scores only its own pixels.
- **Saturation.** `SCORE_W`=20 and a full frame of 2040 → `focus_score`=1,048,575, held and not wrapped.
